spinner_emu: RTL and testbench

SPINNER_EMU -- requirements
Module: spinner_emu

---
 rtl/spinner_emu.sv | 155 +++++++++++++++
 tb/tb_spinner_emu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spinner_emu.sv
`default_nettype none
// ============================================================================
//  Module      : spinner_emu
//  Description : Multi-channel rotary-dial emulator. Each channel turns
//                inc/dec level requests into either a 2-bit level code or an
//                accelerating quadrature (Gray) sequence paced by a shared
//                prescaler tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module spinner_emu #(
    parameter int CHANNELS    = 2,
    parameter int STEP_DIV    = 12000,
    parameter int SLOW_SHIFT  = 3,
    parameter int ACCEL_STEPS = 8
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [CHANNELS-1:0]     inc,
    input  logic [CHANNELS-1:0]     dec,
    input  logic [CHANNELS-1:0]     invert,
    input  logic [CHANNELS-1:0]     mode,
    output logic [2*CHANNELS-1:0]   dial,
    output logic [CHANNELS-1:0]     step
);

    localparam int PW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int RUN_W = $clog2(ACCEL_STEPS + 1);

    localparam logic [1:0]       c_DIR_IDLE = 2'd0;
    localparam logic [1:0]       c_DIR_UP   = 2'd1;
    localparam logic [1:0]       c_DIR_DN   = 2'd2;
    localparam logic [2:0]       c_SLOW     = 3'(SLOW_SHIFT);
    localparam logic [RUN_W-1:0] c_ACCEL    = RUN_W'(ACCEL_STEPS);
    localparam logic [1:0]       c_P_RESET  = 2'd2;

    // Gray code of the phase index: p0=00, p1=01, p2=11, p3=10
    function automatic logic [1:0] f_gray(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    logic [PW-1:0] r_presc;
    logic          w_tick;

    assign w_tick = (r_presc == PW'(STEP_DIV - 1));

    // Shared free-running prescaler producing the base tick
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic             w_up, w_dn, w_active;
        logic [1:0]       w_dir;
        logic [7:0]       w_limit;
        logic [1:0]       r_p,     w_p_nxt;
        logic [1:0]       r_dial,  w_dial_nxt;
        logic             r_step,  w_step_nxt;
        logic [2:0]       r_shift, w_shift_nxt;
        logic [7:0]       r_icnt,  w_icnt_nxt;
        logic [RUN_W-1:0] r_run,   w_run_nxt;
        logic [1:0]       r_last,  w_last_nxt;
        logic             r_mode_q;

        assign w_up     = invert[n] ? dec[n] : inc[n];
        assign w_dn     = invert[n] ? inc[n] : dec[n];
        assign w_active = w_up ^ w_dn;
        assign w_dir    = !w_active ? c_DIR_IDLE : (w_up ? c_DIR_UP : c_DIR_DN);
        assign w_limit  = (8'd1 << r_shift) - 8'd1;

        // Next-state: mode switch reset, level code, or quadrature stepping
        always_comb begin
            w_p_nxt     = r_p;
            w_dial_nxt  = r_dial;
            w_step_nxt  = 1'b0;
            w_shift_nxt = r_shift;
            w_icnt_nxt  = r_icnt;
            w_run_nxt   = r_run;
            w_last_nxt  = r_last;
            if (mode[n] != r_mode_q) begin
                // Mode flipped: channel returns to its reset state
                w_p_nxt     = c_P_RESET;
                w_dial_nxt  = 2'b11;
                w_shift_nxt = c_SLOW;
                w_icnt_nxt  = '0;
                w_run_nxt   = '0;
                w_last_nxt  = c_DIR_IDLE;
            end else if (!mode[n]) begin
                w_dial_nxt  = (w_up && !w_dn) ? 2'b10 :
                              (w_dn && !w_up) ? 2'b01 : 2'b11;
                w_shift_nxt = c_SLOW;
                w_icnt_nxt  = '0;
                w_run_nxt   = '0;
                w_last_nxt  = c_DIR_IDLE;
            end else if (!w_active || (r_last != c_DIR_IDLE && r_last != w_dir)) begin
                // Idle or reversal: restart the slow cadence, phase kept
                w_shift_nxt = c_SLOW;
                w_icnt_nxt  = '0;
                w_run_nxt   = '0;
                w_last_nxt  = w_dir;
            end else begin
                w_last_nxt = w_dir;
                if (w_tick) begin
                    if (r_icnt == w_limit) begin
                        w_p_nxt    = w_up ? (r_p + 2'd1) : (r_p - 2'd1);
                        w_dial_nxt = f_gray(w_p_nxt);
                        w_step_nxt = 1'b1;
                        w_icnt_nxt = '0;
                        if (r_run + 1'b1 == c_ACCEL) begin
                            w_run_nxt   = '0;
                            w_shift_nxt = (r_shift == 3'd0) ? 3'd0 : (r_shift - 3'd1);
                        end else begin
                            w_run_nxt = r_run + 1'b1;
                        end
                    end else begin
                        w_icnt_nxt = r_icnt + 8'd1;
                    end
                end
            end
        end

        // Per-channel state registers
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_p      <= c_P_RESET;
                r_dial   <= 2'b11;
                r_step   <= 1'b0;
                r_shift  <= c_SLOW;
                r_icnt   <= '0;
                r_run    <= '0;
                r_last   <= c_DIR_IDLE;
                r_mode_q <= 1'b0;
            end else begin
                r_p      <= w_p_nxt;
                r_dial   <= w_dial_nxt;
                r_step   <= w_step_nxt;
                r_shift  <= w_shift_nxt;
                r_icnt   <= w_icnt_nxt;
                r_run    <= w_run_nxt;
                r_last   <= w_last_nxt;
                r_mode_q <= mode[n];
            end
        end

        assign dial[2*n +: 2] = r_dial;
        assign step[n]        = r_step;
    end

endmodule
`default_nettype wire

// File: tb/tb_spinner_emu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spinner_emu
//  Description : Self-checking bench for spinner_emu (STEP_DIV=4,
//                SLOW_SHIFT=2, ACCEL_STEPS=2, CHANNELS=2). Expected step
//                events (channel, edge number, dial) are queued up front and
//                popped whenever the DUT pulses step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spinner_emu;

    localparam int CH = 2;

    typedef struct {
        int         ch;
        int         e_at;
        logic [1:0] dl;
    } ev_t;

    logic            clk_sys = 1'b0;
    logic            reset_n = 1'b0;
    logic [CH-1:0]   inc     = '0;
    logic [CH-1:0]   dec     = '0;
    logic [CH-1:0]   invert  = '0;
    logic [CH-1:0]   mode    = '0;
    logic [2*CH-1:0] dial;
    logic [CH-1:0]   step;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  edge_n  = 0;
    int  step_cnt[CH];
    ev_t sb[$];

    spinner_emu #(
        .CHANNELS    (CH),
        .STEP_DIV    (4),
        .SLOW_SHIFT  (2),
        .ACCEL_STEPS (2)
    ) u_dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .inc     (inc),
        .dec     (dec),
        .invert  (invert),
        .mode    (mode),
        .dial    (dial),
        .step    (step)
    );

    always #5 clk_sys = ~clk_sys;

    // Edge number since reset release; edge 1 is the first active edge
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) edge_n <= 0;
        else          edge_n <= edge_n + 1;
    end

    task automatic push(input int c, input int e, input logic [1:0] d);
        ev_t ev;
        ev.ch = c; ev.e_at = e; ev.dl = d;
        sb.push_back(ev);
    endtask

    task automatic start(input logic [CH-1:0] m, input logic [CH-1:0] i,
                         input logic [CH-1:0] d, input logic [CH-1:0] v);
        @(negedge clk_sys);
        reset_n = 1'b0;
        mode = m; inc = i; dec = d; invert = v;
        sb.delete();
        for (int c = 0; c < CH; c++) step_cnt[c] = 0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    // Advance to the negedge after edge 'target', matching step pulses
    task automatic run_to(input int target);
        ev_t ev;
        do begin
            @(negedge clk_sys);
            for (int c = 0; c < CH; c++) begin
                if (step[c] !== 1'b0) begin
                    step_cnt[c]++;
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_step: ch%0d step=%b at edge %0d, none required",
                                 c, step[c], edge_n);
                    end else begin
                        ev = sb.pop_front();
                        if (ev.ch != c || ev.e_at != edge_n || ev.dl !== dial[2*c +: 2]) begin
                            n_fail++;
                            $display("FAIL step_event: got ch%0d edge %0d dial %b, required ch%0d edge %0d dial %b",
                                     c, edge_n, dial[2*c +: 2], ev.ch, ev.e_at, ev.dl);
                        end
                    end
                end
            end
        end while (edge_n < target);
    endtask

    task automatic check_drained(input string nm);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_steps: %0d expected steps not seen, required 0 (next ch%0d edge %0d)",
                     nm, sb.size(), sb[0].ch, sb[0].e_at);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (dial !== 4'b1111) begin n_fail++; $display("FAIL reset_dial: got %b required 1111", dial); end
        n_tests++;
        if (step !== 2'b00) begin n_fail++; $display("FAIL reset_step: got %b required 00", step); end
    endtask

    task automatic test_level();
        start(2'b00, 2'b00, 2'b00, 2'b00);
        run_to(1);
        n_tests++;
        if (dial !== 4'b1111) begin n_fail++; $display("FAIL level_idle: got %b required 1111", dial); end
        inc[0] = 1'b1;
        run_to(2);
        n_tests++;
        if (dial[1:0] !== 2'b10) begin n_fail++; $display("FAIL level_up: got %b required 10", dial[1:0]); end
        dec[0] = 1'b1;
        run_to(3);
        n_tests++;
        if (dial[1:0] !== 2'b11) begin n_fail++; $display("FAIL level_both: got %b required 11", dial[1:0]); end
        dec[0] = 1'b0; invert[0] = 1'b1;
        run_to(4);
        n_tests++;
        if (dial[1:0] !== 2'b01) begin n_fail++; $display("FAIL level_invert: got %b required 01", dial[1:0]); end
        dec[1] = 1'b1;
        run_to(5);
        n_tests++;
        if (dial[3:2] !== 2'b01) begin n_fail++; $display("FAIL level_ch1_dn: got %b required 01", dial[3:2]); end
        invert[1] = 1'b1;
        run_to(8);
        n_tests++;
        if (dial[3:2] !== 2'b10) begin n_fail++; $display("FAIL level_ch1_invert: got %b required 10", dial[3:2]); end
        check_drained("level");
    endtask

    task automatic test_async_reset();
        start(2'b01, 2'b01, 2'b00, 2'b00);
        push(0, 16, 2'b10); push(0, 32, 2'b00); push(0, 40, 2'b01);
        run_to(42);
        check_drained("pre_async");
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (dial !== 4'b1111) begin n_fail++; $display("FAIL async_reset_dial: got %b required 1111", dial); end
        n_tests++;
        if (step !== 2'b00) begin n_fail++; $display("FAIL async_reset_step: got %b required 00", step); end
    endtask

    task automatic test_quad_up();
        start(2'b01, 2'b01, 2'b00, 2'b00);
        push(0, 16, 2'b10); push(0, 32, 2'b00); push(0, 40, 2'b01); push(0, 48, 2'b11);
        push(0, 52, 2'b10); push(0, 56, 2'b00); push(0, 60, 2'b01);
        run_to(60);
        inc[0] = 1'b0;
        run_to(75);
        check_drained("quad_up");
        n_tests++;
        if (dial[1:0] !== 2'b01) begin n_fail++; $display("FAIL quad_idle_hold: got %b required 01", dial[1:0]); end
    endtask

    task automatic test_reversal();
        start(2'b01, 2'b01, 2'b00, 2'b00);
        push(0, 16, 2'b10); push(0, 32, 2'b00); push(0, 40, 2'b01);
        push(0, 56, 2'b00); push(0, 72, 2'b10); push(0, 80, 2'b11);
        push(0, 88, 2'b01); push(0, 92, 2'b00);
        run_to(40);
        inc[0] = 1'b0; dec[0] = 1'b1;
        run_to(93);
        check_drained("reversal");
    endtask

    task automatic test_mode_change();
        start(2'b11, 2'b11, 2'b00, 2'b00);
        push(0, 16, 2'b10); push(1, 16, 2'b10);
        push(0, 32, 2'b00); push(1, 32, 2'b00);
        push(0, 40, 2'b01); push(1, 40, 2'b01);
        push(1, 48, 2'b11); push(1, 52, 2'b10); push(1, 56, 2'b00); push(1, 60, 2'b01);
        run_to(40);
        mode[0] = 1'b0;
        run_to(41);
        n_tests++;
        if (dial[1:0] !== 2'b11) begin n_fail++; $display("FAIL mode_change_reset: got %b required 11", dial[1:0]); end
        run_to(42);
        n_tests++;
        if (dial[1:0] !== 2'b10) begin n_fail++; $display("FAIL mode_change_level: got %b required 10", dial[1:0]); end
        run_to(61);
        check_drained("mode_change");
    endtask

    task automatic test_wrap();
        start(2'b11, 2'b10, 2'b01, 2'b10);
        push(0, 16, 2'b01); push(1, 16, 2'b01);
        push(0, 32, 2'b00); push(1, 32, 2'b00);
        push(0, 40, 2'b10); push(1, 40, 2'b10);
        push(0, 48, 2'b11); push(1, 48, 2'b11);
        push(0, 52, 2'b01); push(1, 52, 2'b01);
        push(0, 56, 2'b00); push(1, 56, 2'b00);
        push(0, 60, 2'b10); push(1, 60, 2'b10);
        push(0, 64, 2'b11); push(1, 64, 2'b11);
        run_to(66);
        check_drained("wrap");
        n_tests++;
        if (step_cnt[0] != 8) begin n_fail++; $display("FAIL wrap_count_ch0: got %0d required 8", step_cnt[0]); end
        n_tests++;
        if (step_cnt[1] != 8) begin n_fail++; $display("FAIL wrap_count_ch1: got %0d required 8", step_cnt[1]); end
        n_tests++;
        if (dial !== 4'b1111) begin n_fail++; $display("FAIL wrap_dial: got %b required 1111", dial); end
    endtask

    initial begin
        test_reset();
        test_level();
        test_async_reset();
        test_quad_up();
        test_reversal();
        test_mode_change();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
